joybus_rx: RTL

Joybus response receiver. Sits directly downstream of the joybus injection transmitter on the same single-wire line. `rx_start` is driven by the transmitter's `tx_done` pulse. The block measures the low time of each controller-driven pulse and classifies it as a 1 or 0 bit. It assembles up to MAX_BITS bits, consumes the trailing stop pulse, and pulses `rx_done`. The transmitter waits on `rx_done` to return to idle.

---
 rtl/joybus_rx_if.sv | 12 +
 rtl/joybus_rx.sv | 96 +++++++++
 2 files changed

// File: rtl/joybus_rx_if.sv
// joybus_rx_if: control, line and result signals of the joybus response receiver
interface joybus_rx_if #(parameter int MAX_BITS = 32);
  logic                rx_start;
  logic [5:0]          rx_len;
  logic                jb_rx;
  logic [MAX_BITS-1:0] rx_data;
  logic                rx_busy;
  logic                rx_done;
  logic                rx_timeout;
  modport master (output rx_start, rx_len, jb_rx, input rx_data, rx_busy, rx_done, rx_timeout);
  modport slave (input rx_start, rx_len, jb_rx, output rx_data, rx_busy, rx_done, rx_timeout);
endinterface

// File: rtl/joybus_rx.sv
// joybus_rx: measures controller low pulses on the joybus line and assembles the response bits
module joybus_rx #(
  parameter int CLK_PER_US = 50,
  parameter int MAX_BITS   = 32,
  parameter int TIMEOUT_US = 100
) (
  input logic       clk,
  input logic       rst_n,
  joybus_rx_if.slave bus
);
  localparam int TO_MAX = TIMEOUT_US * CLK_PER_US - 1;
  localparam int TW     = $clog2(TIMEOUT_US * CLK_PER_US) + 1;
  localparam int LW     = $clog2(2 * CLK_PER_US) + 1;
  typedef enum logic [1:0] {IDLE, WAIT_FALL, MEAS_LOW, DONE} state_t;
  state_t              state, state_d;
  logic [2:0]          sync;
  logic [TW-1:0]       to_cnt;
  logic [LW-1:0]       low_cnt;
  logic [5:0]          bit_cnt, target;
  logic [MAX_BITS-1:0] data;
  logic                done_q, to_q;
  logic                fall, rise, to_hit, glitch, bit_val, len_ok, enter;
  logic                accept, shift, abort, finish;
  // sync[1] is the synchronized line, sync[2] its one-cycle history
  assign fall    = sync[2] & ~sync[1];
  assign rise    = ~sync[2] & sync[1];
  assign to_hit  = to_cnt == TW'(TO_MAX);
  assign glitch  = low_cnt < LW'(CLK_PER_US / 2);
  assign bit_val = low_cnt < LW'(2 * CLK_PER_US);
  assign len_ok  = bus.rx_len != 6'd0 && bus.rx_len <= 6'(MAX_BITS);
  assign enter   = state_d != state && (state_d == WAIT_FALL || state_d == MEAS_LOW);
  assign bus.rx_data    = data;
  assign bus.rx_busy    = state != IDLE;
  assign bus.rx_done    = done_q;
  assign bus.rx_timeout = to_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // next state and per-cycle strobes; the stop pulse is recognised by count, not by width
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    shift   = 1'b0;
    abort   = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: if (bus.rx_start) begin
        accept  = 1'b1;
        state_d = WAIT_FALL;
      end
      WAIT_FALL: if (fall) state_d = MEAS_LOW;
      else if (to_hit) begin
        abort   = 1'b1;
        state_d = IDLE;
      end
      MEAS_LOW: if (rise) begin
        state_d = glitch ? WAIT_FALL : bit_cnt == target ? DONE : WAIT_FALL;
        shift   = !glitch && bit_cnt != target;
      end else if (to_hit) begin
        abort   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  // input synchronizer, counters, shift register and registered done/timeout pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync    <= 3'b111;
      to_cnt  <= '0;
      low_cnt <= '0;
      bit_cnt <= '0;
      target  <= '0;
      data    <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      sync    <= {sync[1:0], bus.jb_rx};
      to_cnt  <= enter ? '0 : (state == WAIT_FALL || state == MEAS_LOW) ? to_cnt + 1'b1 : '0;
      low_cnt <= state != MEAS_LOW ? '0 : &low_cnt ? low_cnt : low_cnt + 1'b1;
      done_q  <= finish | abort;
      to_q    <= abort;
      if (accept) begin
        target  <= len_ok ? bus.rx_len : 6'(MAX_BITS);
        data    <= '0;
        bit_cnt <= '0;
      end else if (shift) begin
        data    <= {data[MAX_BITS-2:0], bit_val};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
endmodule
